// File: rtl/match_qualifier_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : match_qualifier_pkg
//  Description : Shared types for the match qualifier. This package holds the
//                reduction-mode encoding, the mode enum and the enum for the
//                qualifier state machine.
//  Revision    : 1.0  initial release
// ============================================================================
package match_qualifier_pkg;

    // Encoding of the 2-bit mode input
    localparam logic [1:0] c_MODE_ALL     = 2'b00;
    localparam logic [1:0] c_MODE_ANY     = 2'b01;
    localparam logic [1:0] c_MODE_PATTERN = 2'b10;
    localparam logic [1:0] c_MODE_RSVD    = 2'b11;

    typedef enum logic [1:0] {
        ALL     = c_MODE_ALL,
        ANY     = c_MODE_ANY,
        PATTERN = c_MODE_PATTERN,
        RSVD    = c_MODE_RSVD
    } mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        QUAL   = 2'b01,
        ACTIVE = 2'b10
    } state_e;

endpackage
`default_nettype wire

// File: rtl/match_reduce.sv
`default_nettype none
// ============================================================================
//  Module      : match_reduce
//  Description : Purely combinational reduction of the registered inputs
//                under a mask, in ALL / ANY / PATTERN mode.
//  Ports       : in_q      - registered input vector
//                mask      - 1 = bit participates
//                pattern   - expected values for PATTERN mode
//                mode      - reduction mode (reserved value gives 0)
//                match_raw - reduction result
//  Revision    : 1.0  initial release
// ============================================================================
module match_reduce
    import match_qualifier_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] in_q,
    input  logic [WIDTH-1:0] mask,
    input  logic [WIDTH-1:0] pattern,
    input  logic [1:0]       mode,
    output logic             match_raw
);

    always_comb begin
        match_raw = 1'b0;
        // An empty mask never matches; without this check ALL would be
        // vacuously true and PATTERN would always match.
        if (|mask) begin
            case (mode_e'(mode))
                ALL:     match_raw = &(in_q | ~mask);
                ANY:     match_raw = |(in_q & mask);
                PATTERN: match_raw = (((in_q ^ pattern) & mask) == '0);
                default: match_raw = 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/match_qualifier.sv
`default_nettype none
// ============================================================================
//  Module      : match_qualifier
//  Description : Debounced input-match detector. The registered inputs are
//                reduced by match_reduce. The result must hold for
//                hold_cycles+1 consecutive enabled cycles before a qualified
//                match is declared.
//  Ports       : clk, rst_n (sync, active-low), ena (clock enable)
//                in_bits / mask / pattern / mode / hold_cycles - data + config
//                clear       - clears sticky and event_count
//                match_raw   - combinational reduction of in_q
//                match_q     - qualified match level
//                match_pulse - one-cycle pulse on qualification
//                sticky      - set on qualification, held until clear
//                event_count - saturating qualification counter
//  Revision    : 1.0  initial release
// ============================================================================
module match_qualifier
    import match_qualifier_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HOLD_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [WIDTH-1:0]  in_bits,
    input  logic [WIDTH-1:0]  mask,
    input  logic [WIDTH-1:0]  pattern,
    input  logic [1:0]        mode,
    input  logic [HOLD_W-1:0] hold_cycles,
    input  logic              clear,
    output logic              match_raw,
    output logic              match_q,
    output logic              match_pulse,
    output logic              sticky,
    output logic [CNT_W-1:0]  event_count
);

    logic [WIDTH-1:0]  r_in_q;
    state_e            r_state;
    state_e            w_state_nxt;
    logic [HOLD_W-1:0] r_cnt;
    logic [HOLD_W-1:0] w_cnt_nxt;
    logic              r_pulse;
    logic              r_sticky;
    logic [CNT_W-1:0]  r_event_count;
    logic              w_raw;
    logic              w_entry;

    match_reduce #(
        .WIDTH (WIDTH)
    ) u_reduce (
        .in_q      (r_in_q),
        .mask      (mask),
        .pattern   (pattern),
        .mode      (mode),
        .match_raw (w_raw)
    );

    // Next-state logic. r_cnt counts the raw=1 cycles already seen in QUAL.
    // hold_cycles is compared live, so lowering it mid-QUAL qualifies on
    // the next raw=1 cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_raw) begin
                    if (hold_cycles == '0) begin
                        w_state_nxt = ACTIVE;
                    end else begin
                        w_state_nxt = QUAL;
                        w_cnt_nxt   = HOLD_W'(1);
                    end
                end
            end
            QUAL: begin
                if (!w_raw) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= hold_cycles) begin
                    w_state_nxt = ACTIVE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt != '1) begin
                    w_cnt_nxt   = r_cnt + HOLD_W'(1);
                end
            end
            ACTIVE: begin
                if (!w_raw) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_entry = (r_state != ACTIVE) && (w_state_nxt == ACTIVE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_in_q        <= '0;
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_pulse       <= 1'b0;
            r_sticky      <= 1'b0;
            r_event_count <= '0;
        end else if (ena) begin
            r_in_q  <= in_bits;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pulse <= w_entry;
            // An entry in the same cycle as clear wins: the count restarts at 1.
            if (w_entry) begin
                r_sticky <= 1'b1;
                if (clear) begin
                    r_event_count <= CNT_W'(1);
                end else if (r_event_count != '1) begin
                    r_event_count <= r_event_count + CNT_W'(1);
                end
            end else if (clear) begin
                r_sticky      <= 1'b0;
                r_event_count <= '0;
            end
        end else begin
            r_pulse <= 1'b0;
        end
    end

    assign match_raw   = w_raw;
    assign match_q     = (r_state == ACTIVE);
    assign match_pulse = r_pulse;
    assign sticky      = r_sticky;
    assign event_count = r_event_count;

endmodule
`default_nettype wire

// File: tb/tb_match_qualifier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_match_qualifier
//  Description : Self-checking bench for match_qualifier. Two instances share
//                their inputs: the default CNT_W=8 and a CNT_W=2 copy that
//                exercises counter saturation. Expected outputs come from a
//                run-length reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_match_qualifier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, ena, clear;
    logic [7:0] in_bits, mask, pattern;
    logic [1:0] mode;
    logic [3:0] hold_cycles;

    logic       match_raw, match_q, match_pulse, sticky;
    logic [7:0] event_count;
    logic       raw2, q2, p2, s2;
    logic [1:0] ec2;

    match_qualifier #(.WIDTH(8), .HOLD_W(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_bits(in_bits), .mask(mask),
        .pattern(pattern), .mode(mode), .hold_cycles(hold_cycles), .clear(clear),
        .match_raw(match_raw), .match_q(match_q), .match_pulse(match_pulse),
        .sticky(sticky), .event_count(event_count)
    );

    match_qualifier #(.WIDTH(8), .HOLD_W(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_bits(in_bits), .mask(mask),
        .pattern(pattern), .mode(mode), .hold_cycles(hold_cycles), .clear(clear),
        .match_raw(raw2), .match_q(q2), .match_pulse(p2),
        .sticky(s2), .event_count(ec2)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit [7:0] m_in_q;
    bit       m_active, m_pulse, m_sticky;
    int       m_run;      // consecutive raw=1 enabled edges seen so far
    int       m_cnt8, m_cnt2;

    function automatic bit ref_raw(bit [7:0] v, bit [7:0] mk, bit [7:0] pt, bit [1:0] md);
        if (mk == 8'h00) return 1'b0;
        case (md)
            2'd0:    return (v & mk) == mk;
            2'd1:    return (v & mk) != 8'h00;
            2'd2:    return (v & mk) == (pt & mk);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [17:0] dut_vec();
        return {match_raw, match_q, match_pulse, sticky, event_count,
                raw2, q2, p2, s2, ec2};
    endfunction

    function automatic logic [17:0] exp_vec();
        bit r;
        r = ref_raw(m_in_q, mask, pattern, mode);
        return {r, m_active, m_pulse, m_sticky, 8'(m_cnt8),
                r, m_active, m_pulse, m_sticky, 2'(m_cnt2)};
    endfunction

    // One clock edge: update the model from pre-edge inputs, then sample
    // the DUT 1 time unit after the edge.
    task automatic tick();
        bit raw, entry;
        raw = ref_raw(m_in_q, mask, pattern, mode);
        if (!rst_n) begin
            m_in_q = '0; m_active = 0; m_pulse = 0; m_sticky = 0;
            m_run = 0; m_cnt8 = 0; m_cnt2 = 0;
        end else if (ena) begin
            // Qualify when raw has already been 1 on hold_cycles prior edges
            entry    = !m_active && raw && (m_run >= int'(hold_cycles));
            m_active = raw && (m_active || entry);
            m_run    = raw ? ((m_run < 1000) ? m_run + 1 : m_run) : 0;
            m_pulse  = entry;
            if (entry) begin
                m_sticky = 1;
                m_cnt8 = clear ? 1 : ((m_cnt8 < 255) ? m_cnt8 + 1 : 255);
                m_cnt2 = clear ? 1 : ((m_cnt2 < 3) ? m_cnt2 + 1 : 3);
            end else if (clear) begin
                m_sticky = 0; m_cnt8 = 0; m_cnt2 = 0;
            end
            m_in_q = in_bits;
        end else begin
            m_pulse = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        ena = 1; clear = 0; in_bits = 8'hFF; mask = 8'hFF; pattern = 8'h00;
        mode = 2'd0; hold_cycles = 4'd0;
        rst_n = 1'b0;
        tick(); tick();
        if (dut_vec() !== 18'h0) begin
            failures++; $display("FAIL reset_state: got %h expected %h", dut_vec(), 18'h0);
        end
        checks++;
        rst_n = 1'b1;
    endtask

    task automatic test_all_hold0();
        mode = 2'd0; mask = 8'h8F; hold_cycles = 4'd0; in_bits = 8'h8F;
        do_reset();
        tick();   // first sample into in_q
        if (dut_vec() !== exp_vec()) begin
            failures++; $display("FAIL all_h0_sample: got %h expected %h", dut_vec(), exp_vec());
        end
        checks++;
        tick();
        if ({match_q, match_pulse, sticky, event_count} !== {3'b111, 8'd1} ||
            dut_vec() !== exp_vec()) begin
            failures++; $display("FAIL all_h0_qualify: got %h expected %h", dut_vec(), exp_vec());
        end
        checks++;
        tick();
        if (match_pulse !== 1'b0 || match_q !== 1'b1 || dut_vec() !== exp_vec()) begin
            failures++; $display("FAIL all_h0_pulse_end: got %h expected %h", dut_vec(), exp_vec());
        end
        checks++;
    endtask

    task automatic test_all_hold3();
        mode = 2'd0; mask = 8'h8F; hold_cycles = 4'd3;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            in_bits = (i < 3) ? 8'h8F : 8'h0F;
            tick();
            if (dut_vec() !== exp_vec() || event_count !== 8'd0) begin
                failures++; $display("FAIL all_h3_short cyc %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
            checks++;
        end
        for (int i = 0; i < 6; i++) begin
            in_bits = (i < 4) ? 8'h8F : 8'h0F;
            tick();
            if (dut_vec() !== exp_vec() || match_q !== (i == 4 ? 1'b1 : (i == 5 ? match_q : 1'b0))) begin
                failures++; $display("FAIL all_h3_long cyc %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
            checks++;
        end
        if (event_count !== 8'd1) begin
            failures++; $display("FAIL all_h3_count: got %0d expected 1", event_count);
        end
        checks++;
    endtask

    task automatic test_any();
        bit [7:0] seq [5];
        seq = '{8'h10, 8'h00, 8'h20, 8'h00, 8'h00};
        mode = 2'd1; mask = 8'h30; hold_cycles = 4'd0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_bits = seq[i];
            tick();
            if (dut_vec() !== exp_vec()) begin
                failures++; $display("FAIL any_seq cyc %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
            checks++;
        end
        if (event_count !== 8'd2 || sticky !== 1'b1) begin
            failures++; $display("FAIL any_two_pulses: got count %0d expected 2", event_count);
        end
        checks++;
        mask = 8'h00;
        for (int i = 0; i < 6; i++) begin
            in_bits = 8'($urandom);
            mode = 2'($urandom_range(0, 3));
            tick();
            if (match_raw !== 1'b0 || dut_vec() !== exp_vec()) begin
                failures++; $display("FAIL any_mask0 cyc %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
            checks++;
        end
    endtask

    task automatic test_pattern();
        mode = 2'd2; mask = 8'hFF; pattern = 8'hA5; hold_cycles = 4'd1;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            if (i < 3)      begin in_bits = 8'hA5; mode = 2'd2; end
            else if (i < 8) begin in_bits = 8'hA4; mode = 2'd2; end
            else            begin in_bits = 8'hA5; mode = 2'd3; end
            tick();
            if (dut_vec() !== exp_vec()) begin
                failures++; $display("FAIL pattern cyc %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
            checks++;
            if (i == 2 && match_q !== 1'b1) begin
                failures++; $display("FAIL pattern_hit: got match_q %b expected 1", match_q);
            end
            if (i == 2) checks++;
        end
        if (event_count !== 8'd1 || match_q !== 1'b0) begin
            failures++; $display("FAIL pattern_miss_rsvd: got count %0d q %b expected 1 0", event_count, match_q);
        end
        checks++;
    endtask

    task automatic test_ena_freeze();
        mode = 2'd0; mask = 8'hFF; hold_cycles = 4'd2;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            in_bits = (i < 4 || i >= 6) ? 8'hFF : 8'h00;
            tick();
            if (dut_vec() !== exp_vec()) begin
                failures++; $display("FAIL freeze_pre cyc %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
            checks++;
        end
        ena = 0; clear = 1; in_bits = 8'h00;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (dut_vec() !== exp_vec() || sticky !== 1'b1 || event_count !== 8'd1 || match_q !== 1'b0) begin
                failures++; $display("FAIL freeze_hold cyc %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
            checks++;
        end
        ena = 1; clear = 0; in_bits = 8'hFF;
        tick();
        if (match_q !== 1'b0 || dut_vec() !== exp_vec()) begin
            failures++; $display("FAIL freeze_resume1: got %h expected %h", dut_vec(), exp_vec());
        end
        checks++;
        tick();
        if (match_q !== 1'b1 || match_pulse !== 1'b1 || event_count !== 8'd2 || dut_vec() !== exp_vec()) begin
            failures++; $display("FAIL freeze_resume2: got %h expected %h", dut_vec(), exp_vec());
        end
        checks++;
    endtask

    task automatic test_saturate();
        mode = 2'd0; mask = 8'h01; hold_cycles = 4'd0;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            in_bits = (i % 2 == 0) ? 8'h01 : 8'h00;
            if (i == 10) in_bits = 8'h01;
            tick();
            if (dut_vec() !== exp_vec()) begin
                failures++; $display("FAIL saturate cyc %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
            checks++;
        end
        if (event_count !== 8'd5 || ec2 !== 2'd3) begin
            failures++; $display("FAIL saturate_count: got %0d/%0d expected 5/3", event_count, ec2);
        end
        checks++;
        clear = 1;
        tick();
        clear = 0;
        if (event_count !== 8'd1 || ec2 !== 2'd1 || sticky !== 1'b1 || dut_vec() !== exp_vec()) begin
            failures++; $display("FAIL clear_vs_entry: got %h expected %h", dut_vec(), exp_vec());
        end
        checks++;
        tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        if (dut_vec() !== 18'h0) begin
            failures++; $display("FAIL reset_active: got %h expected %h", dut_vec(), 18'h0);
        end
        checks++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i % 10 == 0) begin
                mode        = 2'($urandom_range(0, 3));
                mask        = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
                pattern     = 8'($urandom);
                hold_cycles = 4'($urandom_range(0, 4));
            end
            if ($urandom_range(0, 15) == 0) hold_cycles = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       in_bits = 8'($urandom);
                1:       in_bits = mask | 8'($urandom);
                2:       in_bits = (pattern & mask) | (8'($urandom) & ~mask);
                default: in_bits = in_bits;
            endcase
            ena   = ($urandom_range(0, 9) != 0);
            clear = ($urandom_range(0, 19) == 0);
            rst_n = ($urandom_range(0, 99) != 0);
            tick();
            if (dut_vec() !== exp_vec()) begin
                failures++; $display("FAIL random cyc %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
            checks++;
        end
        rst_n = 1; ena = 1; clear = 0;
    endtask

    initial begin
        m_in_q = '0; m_active = 0; m_pulse = 0; m_sticky = 0;
        m_run = 0; m_cnt8 = 0; m_cnt2 = 0;
        test_reset();
        test_all_hold0();
        test_all_hold3();
        test_any();
        test_pattern();
        test_ena_freeze();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
